masked_share_gen: RTL and testbench

//  Splitting end of the masked adder datapath: takes plain N-bit operands a, b plus
//  a carry-in and emits 2-share Boolean-masked operands (a0^a1 == a, b0^b1 == b).

---
 rtl/masked_share_gen.sv | 119 +++++++++++
 tb/tb_masked_share_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/masked_share_gen.sv
// Splits plain operands into 2-share Boolean-masked operands using masks from an
// internal Galois LFSR, buffered by a 2-entry FIFO. Optional macro: SHARE_RESEED_EN.
module masked_share_gen #(
    parameter int              N      = 4,
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
`ifdef SHARE_RESEED_EN
    input  logic              reseed_valid,
    input  logic [LFSR_W-1:0] reseed_data,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a0,
    output logic [N-1:0] a1,
    output logic [N-1:0] b0,
    output logic [N-1:0] b1,
    output logic         c_out
);

    localparam int                EW = 4 * N + 1;
    localparam logic [LFSR_W-1:0] FB = LFSR_W'(16'hB400);

    if (2 * N > LFSR_W) begin : g_width_check
        $error("masked_share_gen: 2*N must not exceed LFSR_W");
    end

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] lfsr_step;

    logic [EW-1:0] mem_reg [0:1];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;

    logic [N-1:0]  m_a;
    logic [N-1:0]  m_b;
    logic [N-1:0]  a_masked;
    logic [N-1:0]  b_masked;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    // Masks are taken from the LFSR value present before this edge's advance.
    assign m_a = lfsr_reg[N-1:0];
    assign m_b = lfsr_reg[2*N-1:N];

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign a_masked[gi] = a[gi] ^ m_a[gi];
        assign b_masked[gi] = b[gi] ^ m_b[gi];
    end

    assign entry_in = {a_masked, m_a, b_masked, m_b, c_in};

    assign in_ready  = (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        lfsr_step = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? FB : '0);
        lfsr_next = (lfsr_step == '0) ? SEED : lfsr_step;
`ifdef SHARE_RESEED_EN
        if (reseed_valid) begin
            lfsr_next = (reseed_data == '0) ? SEED : reseed_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= entry_in;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs always reflect the head slot; cleared storage makes them zero after reset.
    assign head  = mem_reg[rd_ptr_reg];
    assign a0    = head[4*N:3*N+1];
    assign a1    = head[3*N:2*N+1];
    assign b0    = head[2*N:N+1];
    assign b1    = head[N:1];
    assign c_out = head[0];

endmodule

// File: tb/tb_masked_share_gen.sv
// Directed self-checking bench for masked_share_gen; reseed scenario runs when
// SHARE_RESEED_EN is defined.
module tb_masked_share_gen;

    localparam int          N    = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] a0;
    logic [N-1:0] a1;
    logic [N-1:0] b0;
    logic [N-1:0] b1;
    logic         c_out;
`ifdef SHARE_RESEED_EN
    logic         reseed_valid;
    logic [15:0]  reseed_data;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference mask source, used only where masks cannot be hand-tabulated.
    logic [15:0] model_lfsr;

    always #5 clk = ~clk;

    masked_share_gen #(.N(N), .LFSR_W(16), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SHARE_RESEED_EN
        .reseed_valid (reseed_valid),
        .reseed_data  (reseed_data),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .c_out     (c_out)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_lfsr <= SEED;
`ifdef SHARE_RESEED_EN
        end else if (reseed_valid) begin
            model_lfsr <= (reseed_data == 16'h0) ? SEED : reseed_data;
`endif
        end else begin
            model_lfsr <= (model_lfsr >> 1) ^ (model_lfsr[0] ? 16'hB400 : 16'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
        check_cnt++; if ({a0, a1, b0, b1, c_out} !== 17'h0) $display("FAIL reset_outputs got %h exp 0", {a0, a1, b0, b1, c_out}); else pass_cnt++;
        check_cnt++; if (dut.lfsr_reg !== 16'hACE1) $display("FAIL reset_lfsr got %h exp ACE1", dut.lfsr_reg); else pass_cnt++;
        rst = 1'b0;
        $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    task automatic test_first_push();
        in_valid = 1'b1; a = 4'h5; b = 4'h3; c_in = 1'b1;
        tick();
        in_valid = 1'b0;
        $display("first_push: a0=%h a1=%h b0=%h b1=%h c=%b", a0, a1, b0, b1, c_out);
        check_cnt++; if (out_valid !== 1'b1) $display("FAIL first_out_valid got %b exp 1", out_valid); else pass_cnt++;
        check_cnt++; if (a0 !== 4'h4) $display("FAIL first_a0 got %h exp 4", a0); else pass_cnt++;
        check_cnt++; if (a1 !== 4'h1) $display("FAIL first_a1 got %h exp 1", a1); else pass_cnt++;
        check_cnt++; if (b0 !== 4'hD) $display("FAIL first_b0 got %h exp D", b0); else pass_cnt++;
        check_cnt++; if (b1 !== 4'hE) $display("FAIL first_b1 got %h exp E", b1); else pass_cnt++;
        check_cnt++; if (c_out !== 1'b1) $display("FAIL first_c_out got %b exp 1", c_out); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL first_drain_valid got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_lfsr_sequence();
        rst = 1'b1; #2; rst = 1'b0;
        check_cnt++; if (dut.lfsr_reg !== 16'hACE1) $display("FAIL lfsr_step0 got %h exp ACE1", dut.lfsr_reg); else pass_cnt++;
        tick();
        check_cnt++; if (dut.lfsr_reg !== 16'hE270) $display("FAIL lfsr_step1 got %h exp E270", dut.lfsr_reg); else pass_cnt++;
        tick();
        check_cnt++; if (dut.lfsr_reg !== 16'h7138) $display("FAIL lfsr_step2 got %h exp 7138", dut.lfsr_reg); else pass_cnt++;
        in_valid = 1'b1; a = 4'h0; b = 4'h0; c_in = 1'b0;
        tick();
        in_valid = 1'b0;
        $display("lfsr_push: lfsr=%h a1=%h b1=%h", dut.lfsr_reg, a1, b1);
        check_cnt++; if (dut.lfsr_reg !== 16'h389C) $display("FAIL lfsr_step3 got %h exp 389C", dut.lfsr_reg); else pass_cnt++;
        check_cnt++; if (a1 !== 4'h8) $display("FAIL lfsr_push_a1 got %h exp 8", a1); else pass_cnt++;
        check_cnt++; if (b1 !== 4'h3) $display("FAIL lfsr_push_b1 got %h exp 3", b1); else pass_cnt++;
        check_cnt++; if (a0 !== 4'h8) $display("FAIL lfsr_push_a0 got %h exp 8", a0); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] ma1, mb1, ma2, mb2;
        out_ready = 1'b0;
        ma1 = model_lfsr[3:0]; mb1 = model_lfsr[7:4];
        in_valid = 1'b1; a = 4'h1; b = 4'h2; c_in = 1'b0;
        tick();
        ma2 = model_lfsr[3:0]; mb2 = model_lfsr[7:4];
        a = 4'h3; b = 4'h4; c_in = 1'b1;
        tick();
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b exp 0", in_ready); else pass_cnt++;
        a = 4'h7; b = 4'h7; c_in = 1'b1;
        repeat (2) tick();
        $display("backpressure: head a0=%h a1=%h b0=%h b1=%h c=%b", a0, a1, b0, b1, c_out);
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_held_in_ready got %b exp 0", in_ready); else pass_cnt++;
        check_cnt++; if ({a0, a1, b0, b1, c_out} !== {4'h1 ^ ma1, ma1, 4'h2 ^ mb1, mb1, 1'b0})
            $display("FAIL bp_head1 got %h exp %h", {a0, a1, b0, b1, c_out}, {4'h1 ^ ma1, ma1, 4'h2 ^ mb1, mb1, 1'b0}); else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_pop_in_ready got %b exp 1", in_ready); else pass_cnt++;
        check_cnt++; if ({a0, a1, b0, b1, c_out} !== {4'h3 ^ ma2, ma2, 4'h4 ^ mb2, mb2, 1'b1})
            $display("FAIL bp_head2 got %h exp %h", {a0, a1, b0, b1, c_out}, {4'h3 ^ ma2, ma2, 4'h4 ^ mb2, mb2, 1'b1}); else pass_cnt++;
        tick();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty_valid got %b exp 0", out_valid); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ma, mb, ea, eb;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ea = 4'(i); eb = 4'(15 - i);
            a = ea; b = eb; c_in = ea[0];
            ma = model_lfsr[3:0]; mb = model_lfsr[7:4];
            tick();
            $display("stream %0d: a=%h b=%h -> a0=%h a1=%h b0=%h b1=%h c=%b", i, ea, eb, a0, a1, b0, b1, c_out);
            check_cnt++; if ({out_valid, in_ready} !== 2'b11) $display("FAIL stream_flags[%0d] got %b exp 11", i, {out_valid, in_ready}); else pass_cnt++;
            check_cnt++; if ((a0 ^ a1) !== ea || (b0 ^ b1) !== eb) $display("FAIL stream_unmask[%0d] got %h%h exp %h%h", i, a0 ^ a1, b0 ^ b1, ea, eb); else pass_cnt++;
            check_cnt++; if ({a1, b1, c_out} !== {ma, mb, ea[0]}) $display("FAIL stream_mask[%0d] got %h exp %h", i, {a1, b1, c_out}, {ma, mb, ea[0]}); else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid got %b exp 0", out_valid); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 4'hA; b = 4'hB; c_in = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        check_cnt++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL mid_full got %b exp 10", {out_valid, in_ready}); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        $display("reset_mid: out_valid=%b in_ready=%b", out_valid, in_ready);
        check_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL mid_flags got %b exp 01", {out_valid, in_ready}); else pass_cnt++;
        check_cnt++; if ({a0, a1, b0, b1, c_out} !== 17'h0) $display("FAIL mid_outputs got %h exp 0", {a0, a1, b0, b1, c_out}); else pass_cnt++;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; a = 4'h5; b = 4'h3; c_in = 1'b1;
        tick();
        in_valid = 1'b0;
        check_cnt++; if ({a0, a1, b0, b1, c_out} !== {4'h4, 4'h1, 4'hD, 4'hE, 1'b1})
            $display("FAIL mid_reseeded got %h exp %h", {a0, a1, b0, b1, c_out}, {4'h4, 4'h1, 4'hD, 4'hE, 1'b1}); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef SHARE_RESEED_EN
    task automatic test_reseed();
        reseed_valid = 1'b1; reseed_data = 16'h0;
        tick();
        check_cnt++; if (dut.lfsr_reg !== 16'hACE1) $display("FAIL reseed_zero got %h exp ACE1", dut.lfsr_reg); else pass_cnt++;
        reseed_data = 16'h0001;
        tick();
        reseed_valid = 1'b0;
        check_cnt++; if (dut.lfsr_reg !== 16'h0001) $display("FAIL reseed_one got %h exp 0001", dut.lfsr_reg); else pass_cnt++;
        in_valid = 1'b1; a = 4'h0; b = 4'h0; c_in = 1'b0;
        tick();
        in_valid = 1'b0;
        $display("reseed: a1=%h b1=%h", a1, b1);
        check_cnt++; if ({a1, b1} !== 8'h10) $display("FAIL reseed_mask got %h exp 10", {a1, b1}); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
`ifdef SHARE_RESEED_EN
        reseed_valid = 1'b0; reseed_data = 16'h0;
`endif
        test_reset();
        test_first_push();
        test_lfsr_sequence();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef SHARE_RESEED_EN
        test_reseed();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, check_cnt);
        $fatal(1, "timeout");
    end

endmodule
